vga_sync_out: RTL and testbench
===============================

# vga_sync_out

Display-side end of the colour path. Generates 640x480@60 Hz VGA timing from the system clock, publishes the current pixel coordinates and the active-video flag to the pixel source, and samples the 3-bit pixel colour returned by the colour-select logic. It drives registered hsync, vsync and rgb pins that are aligned to one another. It sits between the switch/colour-select logic and the board VGA connector.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync pulse width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync pulse width (lines)
- V_BP, 33, vertical back porch (lines)
- CLK_DIV, 2, system clocks per pixel (50 MHz → 25 MHz); legal range 1..16
- clk  in  1  system clock, single clock domain
- reset_n  in  1  synchronous, active-low reset
- px_color  in  3  {R,G,B} colour for the pixel at pixel_x/pixel_y, combinational from the source
- pixel_x  out  10  horizontal counter, 0..H_TOTAL-1
- pixel_y  out  10  vertical counter, 0..V_TOTAL-1
- video_on  out  1  high when pixel_x < H_ACTIVE and pixel_y < V_ACTIVE
- pixel_tick  out  1  one-clk strobe, once per pixel period
- frame_start  out  1  one-clk strobe on the tick that wraps the counters to (0,0)
- hsync_n  out  1  registered, active-low horizontal sync
- vsync_n  out  1  registered, active-low vertical sync
- rgb  out  3  registered pixel colour; 0 outside active video

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
- Divider counter div runs 0..CLK_DIV-1 and wraps. pixel_tick = (div == CLK_DIV-1). With CLK_DIV=1, pixel_tick is constant 1 out of reset.
- On pixel_tick, h increments. At H_TOTAL-1, h wraps to 0 and v increments. When v = V_TOTAL-1 and h wraps, v also wraps to 0.
- Horizontal phases, decoded from h: ACTIVE 0..639, FRONT 640..655, SYNC 656..751, BACK 752..799. Vertical phases use the same scheme on v: SYNC is lines 490..491.
- pixel_x, pixel_y and video_on are combinational decodes of the counters. frame_start = pixel_tick & (h==H_TOTAL-1) & (v==V_TOTAL-1).
- On pixel_tick the output registers load:
  - hsync_n ← !(h in SYNC)
  - vsync_n ← !(v in SYNC)
  - rgb ← video_on ? px_color : 3'b000
- Between ticks the output registers hold their values.
- All arithmetic is unsigned, 10-bit. Counters never exceed TOTAL-1. Wrap compares are equality against TOTAL-1, never overflow-based.
- Reset values: div=0, h=0, v=0. Outputs: pixel_x=0, pixel_y=0, video_on=1, pixel_tick = (CLK_DIV==1), frame_start=0, hsync_n=1, vsync_n=1, rgb=0.
- Reset asserted mid-frame: on the next clk edge, all of the reset values above apply. Counting restarts from (0,0) on the first clk with reset_n high. No partial sync pulse is stretched.

## Timing
- The source sees pixel_x/pixel_y and must return px_color in the same clk, as a combinational path.
- rgb, hsync_n and vsync_n lag the counter state by exactly one pixel period. All three stay mutually aligned.
- Each counter value lasts CLK_DIV clks. The line period is H_TOTAL×CLK_DIV clks and the frame period is H_TOTAL×V_TOTAL×CLK_DIV clks (840 000 at defaults).
- hsync_n is low for H_SYNC×CLK_DIV clks per line. vsync_n is low for V_SYNC lines (2×800×CLK_DIV clks).
- frame_start and pixel_tick are high for exactly one clk.

## Structure
- Shared package vga_timing_pkg holds:
  - 640x480 timing constants and the derived H_TOTAL/V_TOTAL.
  - Phase boundary constants (H_SYNC_START = H_ACTIVE+H_FP, H_SYNC_END, and the vertical equivalents).
  - Coordinate width constant (10).
  - RGB width constant (3).
- One sub-module, pixel_tick_gen (parameter CLK_DIV; ports clk, reset_n, pixel_tick). It is reused by other display blocks.

## Test plan
- Reset: hold reset_n=0 for 5 clks → hsync_n=1, vsync_n=1, rgb=0, pixel_x=0, pixel_y=0, no pixel_tick.
- Line timing (CLK_DIV=2): measure one line → hsync_n period 1600 clks. hsync_n goes low on the tick after h=656 and stays low for 192 clks.
- Frame timing: run 2 frames → frame_start pulses 840 000 clks apart. vsync_n is low for 3200 clks, starting one pixel after v reaches 490.
- Colour pass-through: px_color=3'b101 constant → rgb=3'b101 one pixel after each h in 0..639 on visible lines. rgb=0 for h≥640 and for v≥480.
- Wrap boundary: observe h=799, v=524 → next tick gives h=0, v=0, frame_start=1 for one clk, video_on=1.
- Mid-frame reset: assert reset_n=0 for one clk at h=700 (inside hsync), v=491 → next clk hsync_n=1, vsync_n=1, rgb=0, counters at 0. Timing then restarts cleanly.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// 640x480@60 Hz timing constants, shared types and the phase decoder used by
// the display-side blocks.
package vga_timing_pkg;

  localparam int COORD_W = 10;
  localparam int RGB_W   = 3;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  // *_SYNC_END is the first position after the pulse (exclusive bound).
  localparam int H_SYNC_START = H_ACTIVE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam int V_SYNC_START = V_ACTIVE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

  localparam int CLK_DIV_DEFAULT = 2;

  typedef logic [COORD_W-1:0] coord_t;
  typedef logic [RGB_W-1:0]   rgb_t;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  typedef struct packed {
    phase_e h_phase;
    phase_e v_phase;
  } sync_dbg_t;

  function automatic phase_e decode_phase(coord_t pos, coord_t front_start,
                                          coord_t sync_start, coord_t back_start);
    if (pos < front_start) begin
      return PH_ACTIVE;
    end else if (pos < sync_start) begin
      return PH_FRONT;
    end else if (pos < back_start) begin
      return PH_SYNC;
    end
    return PH_BACK;
  endfunction

endpackage

// File: rtl/vga_sync_out_if.sv
// Pixel-source and VGA-pin bundle of vga_sync_out. master = timing generator,
// slave = pixel source / connector side.
interface vga_sync_out_if;
  import vga_timing_pkg::*;

  // pixel_tick is the only qualifier: the pixel addressed by pixel_x/pixel_y is
  // consumed on every tick, and the source has no way to stall it.
  rgb_t      px_color;
  coord_t    pixel_x;
  coord_t    pixel_y;
  logic      video_on;
  logic      pixel_tick;
  logic      frame_start;
  logic      hsync_n;
  logic      vsync_n;
  rgb_t      rgb;
  sync_dbg_t dbg;

  modport master (
    input  px_color,
    output pixel_x, pixel_y, video_on, pixel_tick, frame_start,
    output hsync_n, vsync_n, rgb, dbg
  );

  modport slave (
    output px_color,
    input  pixel_x, pixel_y, video_on, pixel_tick, frame_start,
    input  hsync_n, vsync_n, rgb, dbg
  );

endinterface

// File: rtl/vga_sync_out_pixel_tick_gen.sv
// Divides the system clock into a one-clk pixel strobe every CLK_DIV clocks.
// With CLK_DIV=1 the divider stays at zero and the strobe is always high.
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic reset_n,
  output logic pixel_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    pixel_tick = (div_q == DIV_LAST);
    div_d      = pixel_tick ? '0 : div_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q <= '0;
    end else begin
      div_q <= div_d;
    end
  end

endmodule

// File: rtl/vga_sync_out.sv
// VGA timing generator: h/v counters, coordinate publish to the pixel source,
// and registered hsync_n/vsync_n/rgb pins that lag the counters by one pixel.
module vga_sync_out
  import vga_timing_pkg::*;
#(
  parameter int H_ACT   = H_ACTIVE,
  parameter int H_FRONT = H_FP,
  parameter int H_PULSE = H_SYNC,
  parameter int H_BACK  = H_BP,
  parameter int V_ACT   = V_ACTIVE,
  parameter int V_FRONT = V_FP,
  parameter int V_PULSE = V_SYNC,
  parameter int V_BACK  = V_BP,
  parameter int CLK_DIV = CLK_DIV_DEFAULT
) (
  input logic            clk,
  input logic            reset_n,
  vga_sync_out_if.master bus
);

  localparam int HT = H_ACT + H_FRONT + H_PULSE + H_BACK;
  localparam int VT = V_ACT + V_FRONT + V_PULSE + V_BACK;

  localparam coord_t H_LAST   = coord_t'(HT - 1);
  localparam coord_t H_FP_AT  = coord_t'(H_ACT);
  localparam coord_t H_SYN_AT = coord_t'(H_ACT + H_FRONT);
  localparam coord_t H_BP_AT  = coord_t'(H_ACT + H_FRONT + H_PULSE);
  localparam coord_t V_LAST   = coord_t'(VT - 1);
  localparam coord_t V_FP_AT  = coord_t'(V_ACT);
  localparam coord_t V_SYN_AT = coord_t'(V_ACT + V_FRONT);
  localparam coord_t V_BP_AT  = coord_t'(V_ACT + V_FRONT + V_PULSE);

  logic   tick;
  coord_t h_q, h_d;
  coord_t v_q, v_d;
  logic   hsync_n_q, hsync_n_d;
  logic   vsync_n_q, vsync_n_d;
  rgb_t   rgb_q, rgb_d;
  phase_e h_phase, v_phase;
  logic   h_wrap, v_wrap, video_on;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk        (clk),
    .reset_n    (reset_n),
    .pixel_tick (tick)
  );

  always_comb begin
    h_phase   = decode_phase(h_q, H_FP_AT, H_SYN_AT, H_BP_AT);
    v_phase   = decode_phase(v_q, V_FP_AT, V_SYN_AT, V_BP_AT);
    video_on  = (h_phase == PH_ACTIVE) && (v_phase == PH_ACTIVE);
    h_wrap    = (h_q == H_LAST);
    v_wrap    = (v_q == V_LAST);
    h_d       = h_q;
    v_d       = v_q;
    hsync_n_d = hsync_n_q;
    vsync_n_d = vsync_n_q;
    rgb_d     = rgb_q;
    if (tick) begin
      h_d = h_wrap ? '0 : h_q + 1'b1;
      if (h_wrap) begin
        v_d = v_wrap ? '0 : v_q + 1'b1;
      end
      // Pins capture the decode of the pixel being left, hence the one-pixel lag.
      hsync_n_d = (h_phase != PH_SYNC);
      vsync_n_d = (v_phase != PH_SYNC);
      rgb_d     = video_on ? bus.px_color : '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      h_q       <= '0;
      v_q       <= '0;
      hsync_n_q <= 1'b1;
      vsync_n_q <= 1'b1;
      rgb_q     <= '0;
    end else begin
      h_q       <= h_d;
      v_q       <= v_d;
      hsync_n_q <= hsync_n_d;
      vsync_n_q <= vsync_n_d;
      rgb_q     <= rgb_d;
    end
  end

  assign bus.pixel_x     = h_q;
  assign bus.pixel_y     = v_q;
  assign bus.video_on    = video_on;
  assign bus.pixel_tick  = tick;
  assign bus.frame_start = tick & h_wrap & v_wrap;
  assign bus.hsync_n     = hsync_n_q;
  assign bus.vsync_n     = vsync_n_q;
  assign bus.rgb         = rgb_q;
  assign bus.dbg.h_phase = h_phase;
  assign bus.dbg.v_phase = v_phase;

endmodule

// File: tb/tb_vga_sync_out.sv
// Directed bench for vga_sync_out: a full-size instance for line timing and
// colour, plus two reduced-geometry instances for frame, wrap and CLK_DIV=1.
`timescale 1ns/1ps
module tb_vga_sync_out;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n   = 1'b0;
  logic rst_b_n = 1'b0;
  int   total   = 0;
  int   bad     = 0;

  vga_sync_out_if bus_a ();
  vga_sync_out_if bus_b ();
  vga_sync_out_if bus_c ();

  // Full 640x480 geometry, CLK_DIV=2.
  vga_sync_out u_dut_a (.clk(clk), .reset_n(rst_n), .bus(bus_a));

  // Reduced geometry: H_TOTAL=16 (sync 10..12), V_TOTAL=10 (sync 6..7).
  vga_sync_out #(
    .H_ACT(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(3),
    .V_ACT(4), .V_FRONT(2), .V_PULSE(2), .V_BACK(2), .CLK_DIV(2)
  ) u_dut_b (.clk(clk), .reset_n(rst_b_n), .bus(bus_b));

  vga_sync_out #(
    .H_ACT(8), .H_FRONT(2), .H_PULSE(3), .H_BACK(3),
    .V_ACT(4), .V_FRONT(2), .V_PULSE(2), .V_BACK(2), .CLK_DIV(1)
  ) u_dut_c (.clk(clk), .reset_n(rst_n), .bus(bus_c));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n   = 1'b0;
    rst_b_n = 1'b0;
    repeat (5) step();
    total++; if (bus_a.hsync_n !== 1'b1) begin bad++; $display("FAIL reset_hsync_n got=%b exp=1", bus_a.hsync_n); end
    total++; if (bus_a.vsync_n !== 1'b1) begin bad++; $display("FAIL reset_vsync_n got=%b exp=1", bus_a.vsync_n); end
    total++; if (bus_a.rgb !== 3'b000) begin bad++; $display("FAIL reset_rgb got=%b exp=000", bus_a.rgb); end
    total++; if (bus_a.pixel_x !== 10'd0) begin bad++; $display("FAIL reset_pixel_x got=%0d exp=0", bus_a.pixel_x); end
    total++; if (bus_a.pixel_y !== 10'd0) begin bad++; $display("FAIL reset_pixel_y got=%0d exp=0", bus_a.pixel_y); end
    total++; if (bus_a.pixel_tick !== 1'b0) begin bad++; $display("FAIL reset_pixel_tick got=%b exp=0", bus_a.pixel_tick); end
    total++; if (bus_a.video_on !== 1'b1) begin bad++; $display("FAIL reset_video_on got=%b exp=1", bus_a.video_on); end
    total++; if (bus_a.frame_start !== 1'b0) begin bad++; $display("FAIL reset_frame_start got=%b exp=0", bus_a.frame_start); end
    total++; if (bus_c.pixel_tick !== 1'b1) begin bad++; $display("FAIL reset_tick_div1 got=%b exp=1", bus_c.pixel_tick); end
  endtask

  // Edge i counts clk edges after release; pixel p = i/2 is current after edge i.
  task automatic test_line_and_colour();
    int f1, f2, r1, x_at_fall, ticks_line, doubles;
    logic prev_hs, prev_tick;
    f1 = -1; f2 = -1; r1 = -1; x_at_fall = -1; ticks_line = 0; doubles = 0;
    prev_hs = 1'b1; prev_tick = 1'b0;
    bus_a.px_color = 3'b101;
    rst_n = 1'b1;
    for (int i = 1; i <= 3300; i++) begin
      step();
      if (i <= 1600 && bus_a.pixel_tick) ticks_line++;
      if (bus_a.pixel_tick && prev_tick) doubles++;
      if (prev_hs && !bus_a.hsync_n) begin
        if (f1 < 0) begin
          f1 = i;
          x_at_fall = int'(bus_a.pixel_x);
        end else if (f2 < 0) begin
          f2 = i;
        end
      end
      if (!prev_hs && bus_a.hsync_n && f1 >= 0 && r1 < 0) r1 = i;
      prev_hs   = bus_a.hsync_n;
      prev_tick = bus_a.pixel_tick;
      case (i)
        1: begin
          total++; if (bus_a.rgb !== 3'b000) begin bad++; $display("FAIL rgb_before_first_tick got=%b exp=000", bus_a.rgb); end
        end
        2: begin
          total++; if (bus_a.rgb !== 3'b101) begin bad++; $display("FAIL rgb_pixel0 got=%b exp=101", bus_a.rgb); end
          total++; if (bus_a.pixel_x !== 10'd1) begin bad++; $display("FAIL pixel_x_after_tick got=%0d exp=1", bus_a.pixel_x); end
        end
        400: begin
          total++; if (bus_a.rgb !== 3'b010) begin bad++; $display("FAIL rgb_color_change got=%b exp=010", bus_a.rgb); end
        end
        401: begin
          total++; if (bus_a.rgb !== 3'b010) begin bad++; $display("FAIL rgb_hold_between_ticks got=%b exp=010", bus_a.rgb); end
        end
        402: begin
          total++; if (bus_a.rgb !== 3'b101) begin bad++; $display("FAIL rgb_color_restore got=%b exp=101", bus_a.rgb); end
        end
        1278: begin
          total++; if (bus_a.video_on !== 1'b1 || bus_a.pixel_x !== 10'd639) begin bad++; $display("FAIL video_on_x639 got=%b/%0d exp=1/639", bus_a.video_on, bus_a.pixel_x); end
        end
        1280: begin
          total++; if (bus_a.rgb !== 3'b101) begin bad++; $display("FAIL rgb_pixel639 got=%b exp=101", bus_a.rgb); end
          total++; if (bus_a.video_on !== 1'b0) begin bad++; $display("FAIL video_on_x640 got=%b exp=0", bus_a.video_on); end
        end
        1282: begin
          total++; if (bus_a.rgb !== 3'b000) begin bad++; $display("FAIL rgb_pixel640 got=%b exp=000", bus_a.rgb); end
        end
        1600: begin
          total++; if (bus_a.pixel_x !== 10'd0 || bus_a.pixel_y !== 10'd1) begin bad++; $display("FAIL line_wrap got=%0d,%0d exp=0,1", bus_a.pixel_x, bus_a.pixel_y); end
        end
        1602: begin
          total++; if (bus_a.rgb !== 3'b101) begin bad++; $display("FAIL rgb_line1_pixel0 got=%b exp=101", bus_a.rgb); end
        end
        default: ;
      endcase
      if (i == 399) bus_a.px_color = 3'b010;
      if (i == 401) bus_a.px_color = 3'b101;
    end
    total++; if (f1 != 1314) begin bad++; $display("FAIL hsync_first_fall got=%0d exp=1314", f1); end
    total++; if (x_at_fall != 657) begin bad++; $display("FAIL hsync_fall_pixel_x got=%0d exp=657", x_at_fall); end
    total++; if (r1 - f1 != 192) begin bad++; $display("FAIL hsync_low_clks got=%0d exp=192", r1 - f1); end
    total++; if (f2 - f1 != 1600) begin bad++; $display("FAIL hsync_period got=%0d exp=1600", f2 - f1); end
    total++; if (ticks_line != 800) begin bad++; $display("FAIL ticks_per_line got=%0d exp=800", ticks_line); end
    total++; if (doubles != 0) begin bad++; $display("FAIL tick_width got=%0d exp=0", doubles); end
  endtask

  task automatic test_frame_wrap();
    int fs1, fs2, n_fs, vf, vr;
    logic prev_vs;
    fs1 = -1; fs2 = -1; n_fs = 0; vf = -1; vr = -1; prev_vs = 1'b1;
    bus_b.px_color = 3'b110;
    rst_b_n = 1'b0;
    step();
    step();
    rst_b_n = 1'b1;
    for (int i = 1; i <= 700; i++) begin
      step();
      if (bus_b.frame_start) begin
        n_fs++;
        if (fs1 < 0) fs1 = i;
        else if (fs2 < 0) fs2 = i;
      end
      if (prev_vs && !bus_b.vsync_n && vf < 0) vf = i;
      if (!prev_vs && bus_b.vsync_n && vf >= 0 && vr < 0) vr = i;
      prev_vs = bus_b.vsync_n;
      case (i)
        98: begin
          total++; if (bus_b.rgb !== 3'b110) begin bad++; $display("FAIL rgb_last_active_line got=%b exp=110", bus_b.rgb); end
        end
        130: begin
          total++; if (bus_b.rgb !== 3'b000) begin bad++; $display("FAIL rgb_blank_line got=%b exp=000", bus_b.rgb); end
          total++; if (bus_b.video_on !== 1'b0 || bus_b.pixel_y !== 10'd4) begin bad++; $display("FAIL video_on_blank_line got=%b/%0d exp=0/4", bus_b.video_on, bus_b.pixel_y); end
        end
        318: begin
          total++; if (bus_b.pixel_x !== 10'd15 || bus_b.pixel_y !== 10'd9 || bus_b.frame_start !== 1'b0) begin bad++; $display("FAIL pre_wrap got=%0d,%0d,%b exp=15,9,0", bus_b.pixel_x, bus_b.pixel_y, bus_b.frame_start); end
        end
        320: begin
          total++; if (bus_b.pixel_x !== 10'd0 || bus_b.pixel_y !== 10'd0 || bus_b.frame_start !== 1'b0) begin bad++; $display("FAIL post_wrap got=%0d,%0d,%b exp=0,0,0", bus_b.pixel_x, bus_b.pixel_y, bus_b.frame_start); end
          total++; if (bus_b.video_on !== 1'b1) begin bad++; $display("FAIL post_wrap_video_on got=%b exp=1", bus_b.video_on); end
        end
        default: ;
      endcase
    end
    total++; if (fs1 != 319) begin bad++; $display("FAIL frame_start_first got=%0d exp=319", fs1); end
    total++; if (fs2 - fs1 != 320) begin bad++; $display("FAIL frame_period got=%0d exp=320", fs2 - fs1); end
    total++; if (n_fs != 2) begin bad++; $display("FAIL frame_start_count got=%0d exp=2", n_fs); end
    total++; if (vf != 194) begin bad++; $display("FAIL vsync_fall got=%0d exp=194", vf); end
    total++; if (vr - vf != 64) begin bad++; $display("FAIL vsync_low_clks got=%0d exp=64", vr - vf); end
  endtask

  task automatic test_mid_frame_reset();
    int hf, vf, fs;
    logic prev_hs, prev_vs;
    hf = -1; vf = -1; fs = -1; prev_hs = 1'b1; prev_vs = 1'b1;
    rst_b_n = 1'b0;
    step();
    rst_b_n = 1'b1;
    repeat (247) step();
    total++; if (bus_b.pixel_x !== 10'd11 || bus_b.pixel_y !== 10'd7) begin bad++; $display("FAIL mid_reset_position got=%0d,%0d exp=11,7", bus_b.pixel_x, bus_b.pixel_y); end
    total++; if (bus_b.hsync_n !== 1'b0 || bus_b.vsync_n !== 1'b0) begin bad++; $display("FAIL mid_reset_in_sync got=%b,%b exp=0,0", bus_b.hsync_n, bus_b.vsync_n); end
    rst_b_n = 1'b0;
    step();
    total++; if (bus_b.hsync_n !== 1'b1 || bus_b.vsync_n !== 1'b1) begin bad++; $display("FAIL mid_reset_sync got=%b,%b exp=1,1", bus_b.hsync_n, bus_b.vsync_n); end
    total++; if (bus_b.rgb !== 3'b000) begin bad++; $display("FAIL mid_reset_rgb got=%b exp=000", bus_b.rgb); end
    total++; if (bus_b.pixel_x !== 10'd0 || bus_b.pixel_y !== 10'd0) begin bad++; $display("FAIL mid_reset_counters got=%0d,%0d exp=0,0", bus_b.pixel_x, bus_b.pixel_y); end
    total++; if (bus_b.pixel_tick !== 1'b0) begin bad++; $display("FAIL mid_reset_tick got=%b exp=0", bus_b.pixel_tick); end
    rst_b_n = 1'b1;
    for (int i = 1; i <= 330; i++) begin
      step();
      if (prev_hs && !bus_b.hsync_n && hf < 0) hf = i;
      if (prev_vs && !bus_b.vsync_n && vf < 0) vf = i;
      if (bus_b.frame_start && fs < 0) fs = i;
      prev_hs = bus_b.hsync_n;
      prev_vs = bus_b.vsync_n;
    end
    total++; if (hf != 22) begin bad++; $display("FAIL restart_hsync_fall got=%0d exp=22", hf); end
    total++; if (vf != 194) begin bad++; $display("FAIL restart_vsync_fall got=%0d exp=194", vf); end
    total++; if (fs != 319) begin bad++; $display("FAIL restart_frame_start got=%0d exp=319", fs); end
  endtask

  task automatic test_clk_div1();
    bus_c.px_color = 3'b011;
    rst_n = 1'b0;
    step();
    total++; if (bus_c.pixel_tick !== 1'b1 || bus_c.pixel_x !== 10'd0) begin bad++; $display("FAIL div1_reset got=%b,%0d exp=1,0", bus_c.pixel_tick, bus_c.pixel_x); end
    rst_n = 1'b1;
    for (int i = 1; i <= 170; i++) begin
      step();
      case (i)
        1: begin
          total++; if (bus_c.pixel_x !== 10'd1 || bus_c.pixel_tick !== 1'b1) begin bad++; $display("FAIL div1_first got=%0d,%b exp=1,1", bus_c.pixel_x, bus_c.pixel_tick); end
          total++; if (bus_c.rgb !== 3'b011) begin bad++; $display("FAIL div1_rgb got=%b exp=011", bus_c.rgb); end
        end
        5: begin
          total++; if (bus_c.pixel_x !== 10'd5) begin bad++; $display("FAIL div1_count got=%0d exp=5", bus_c.pixel_x); end
        end
        159: begin
          total++; if (bus_c.frame_start !== 1'b1 || bus_c.pixel_x !== 10'd15 || bus_c.pixel_y !== 10'd9) begin bad++; $display("FAIL div1_frame_start got=%b,%0d,%0d exp=1,15,9", bus_c.frame_start, bus_c.pixel_x, bus_c.pixel_y); end
        end
        160: begin
          total++; if (bus_c.frame_start !== 1'b0 || bus_c.pixel_x !== 10'd0 || bus_c.pixel_y !== 10'd0) begin bad++; $display("FAIL div1_wrap got=%b,%0d,%0d exp=0,0,0", bus_c.frame_start, bus_c.pixel_x, bus_c.pixel_y); end
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    bus_a.px_color = 3'b101;
    bus_b.px_color = 3'b110;
    bus_c.px_color = 3'b011;
    test_reset();
    test_line_and_colour();
    test_frame_wrap();
    test_mid_frame_reset();
    test_clk_div1();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
